// File: rtl/team_00_wb_responder.sv
// -----------------------------------------------------------------------------
// team_00_wb_responder
//   Wishbone classic subordinate that exposes the team_00 core control and
//   status registers to the bus manager. It drives enable, a one-cycle start
//   pulse and the prescaler into the core. It captures busy/done status, and it
//   raises a maskable interrupt when done_i rises.
//
// Ports
//   clk, nrst                      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i     Wishbone request qualifiers
//   wbs_adr_i, wbs_dat_i           byte address / write data
//   wbs_ack_o, wbs_dat_o           one-cycle acknowledge / read data (0 unless ack)
//   en_o, start_o, prescaler_o     core controls
//   busy_i, done_i                 core status (done rising edge is the event)
//   irq_o                          done_sticky & irq_en
//
// Register map (offset = adr[7:0], adr[1:0] ignored)
//   0x00 CTRL      [0] en, [1] start (self-clearing, reads 0), [2] irq_en
//   0x04 PRESCALER [13:0]
//   0x08 STATUS    [0] done_sticky (W1C), [1] busy_i (RO)
//   0x0C SCRATCH   [31:0]
//   0x10 ID        ID_VALUE (RO)
//   others         read 0, writes ignored, still acked
// -----------------------------------------------------------------------------
module team_00_wb_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned WAIT_STATES   = 0,
  parameter logic [13:0] PRESCALER_RST = 14'd1000,
  parameter logic [31:0] ID_VALUE      = 32'h7EA0_0001
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        en_o,
  output logic        start_o,
  output logic [13:0] prescaler_o,
  input  logic        busy_i,
  input  logic        done_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  // Word offsets (adr[7:2])
  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_PRESC   = 6'h01;
  localparam logic [5:0] OFF_STATUS  = 6'h02;
  localparam logic [5:0] OFF_SCRATCH = 6'h03;
  localparam logic [5:0] OFF_ID      = 6'h04;

  // Handshake state and latched request
  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic [5:0]  adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;
  logic        ack_q;
  logic [31:0] rdat_q;

  // Register file
  logic        en_q;
  logic        irqen_q;
  logic        start_q;
  logic [13:0] presc_q;
  logic [31:0] scratch_q;
  logic        sticky_q;
  logic        sticky_d;
  logic        done_d1_q;

  // Transfer view used on the commit edge
  logic        req;
  logic        hit;
  logic        go_ack;
  logic [5:0]  t_off;
  logic        t_we;
  logic [3:0]  t_sel;
  logic [31:0] t_wdat;
  logic        wr_en;
  logic        clr_done;
  logic        done_rise;
  logic [31:0] rd_val;

  logic        unused_adr_lsb;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign req = wbs_cyc_i & wbs_stb_i;
  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // With no wait states the transfer commits on the very edge that samples it,
  // so the live bus fields are used there; otherwise the latched copy is used.
  always_comb begin
    t_off  = adr_q;
    t_we   = we_q;
    t_sel  = sel_q;
    t_wdat = wdat_q;
    go_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        t_off  = wbs_adr_i[7:2];
        t_we   = wbs_we_i;
        t_sel  = wbs_sel_i;
        t_wdat = wbs_dat_i;
        go_ack = NO_WAIT && req && hit;
      end
      S_WAIT:  go_ack = req && (wait_cnt_q == LAST_WAIT);
      default: go_ack = 1'b0;
    endcase
  end

  assign wr_en     = go_ack && t_we;
  assign clr_done  = wr_en && (t_off == OFF_STATUS) && t_sel[0] && t_wdat[0];
  assign done_rise = done_i & ~done_d1_q;
  // A fresh done edge wins over a same-cycle clear.
  assign sticky_d  = done_rise | (sticky_q & ~clr_done);

  always_comb begin
    rd_val = '0;
    case (t_off)
      OFF_CTRL:    rd_val = {29'd0, irqen_q, 1'b0, en_q};
      OFF_PRESC:   rd_val = {18'd0, presc_q};
      OFF_STATUS:  rd_val = {30'd0, busy_i, sticky_q};
      OFF_SCRATCH: rd_val = scratch_q;
      OFF_ID:      rd_val = ID_VALUE;
      default:     rd_val = '0;
    endcase
  end

  // Handshake FSM with registered ack / read data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdat_q     <= '0;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
    end else begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            adr_q      <= wbs_adr_i[7:2];
            we_q       <= wbs_we_i;
            sel_q      <= wbs_sel_i;
            wdat_q     <= wbs_dat_i;
            wait_cnt_q <= '0;
            if (go_ack) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              rdat_q  <= t_we ? '0 : rd_val;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
          end else if (go_ack) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            rdat_q  <= t_we ? '0 : rd_val;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register file, written on the commit edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= 1'b0;
      irqen_q   <= 1'b0;
      start_q   <= 1'b0;
      presc_q   <= PRESCALER_RST;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      done_d1_q <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      done_d1_q <= done_i;
      sticky_q  <= sticky_d;
      if (wr_en) begin
        case (t_off)
          OFF_CTRL: begin
            if (t_sel[0]) begin
              en_q    <= t_wdat[0];
              start_q <= t_wdat[1];
              irqen_q <= t_wdat[2];
            end
          end
          OFF_PRESC: begin
            if (t_sel[0]) presc_q[7:0]  <= t_wdat[7:0];
            if (t_sel[1]) presc_q[13:8] <= t_wdat[13:8];
          end
          OFF_SCRATCH: begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (t_sel[b]) scratch_q[8*b +: 8] <= t_wdat[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign en_o        = en_q;
  assign start_o     = start_q;
  assign prescaler_o = presc_q;
  assign irq_o       = sticky_q & irqen_q;

endmodule
